lock_controller: RTL

Sequencing controller for the 4-digit code lock. It takes keypad events, drives the 16-bit nibble shift register (load, clear, digit data), and compares the entered code against a fixed code when the user presses enter. It also grants a timed unlock, counts failed attempts and enforces a timed lockout with an alarm. It sits between the keypad decoder and the shift register/actuator outputs of the lock top level.

---
 rtl/lock_controller.sv | 134 +++++++++++++
 1 files changed

// File: rtl/lock_controller.sv
// Sequencing controller for the 4-digit code lock: steers the external nibble
// shift register, checks the entered code, and runs the unlock and lockout timers.
module lock_controller #(
    parameter logic [15:0] CODE           = 16'h4321,
    parameter int          MAX_TRIES      = 3,
    parameter int          UNLOCK_CYCLES  = 50,
    parameter int          LOCKOUT_CYCLES = 200,
    localparam int         FAIL_W         = $clog2(MAX_TRIES + 1)
) (
    input  logic              clk,
    input  logic              clr,
    input  logic              key_valid,
    input  logic [3:0]        key_code,
    input  logic [15:0]       sr_q,
    output logic              sr_load,
    output logic              sr_clr,
    output logic [3:0]        sr_data,
    output logic [2:0]        digit_cnt,
    output logic [FAIL_W-1:0] fail_cnt,
    output logic              unlocked,
    output logic              alarm,
    output logic              bad_code
);

    localparam int TMR_MAX = (UNLOCK_CYCLES > LOCKOUT_CYCLES) ? UNLOCK_CYCLES : LOCKOUT_CYCLES;
    localparam int TMR_W   = $clog2(TMR_MAX + 1);

    localparam logic [TMR_W-1:0]  OPEN_LOAD  = TMR_W'(UNLOCK_CYCLES - 1);
    localparam logic [TMR_W-1:0]  LOCK_LOAD  = TMR_W'(LOCKOUT_CYCLES - 1);
    localparam logic [FAIL_W-1:0] FAIL_LIMIT = FAIL_W'(MAX_TRIES);
    localparam logic [3:0]        KEY_CLEAR  = 4'hA;
    localparam logic [3:0]        KEY_ENTER  = 4'hB;

    typedef enum logic [1:0] {ENTRY, CHECK, OPEN, LOCKOUT} state_t;

    state_t            state;
    logic [TMR_W-1:0]  timer;

    logic              entry_key;
    logic              full;
    logic              digit_ok;
    logic              clear_key;
    logic              enter_key;
    logic              short_enter;
    logic [FAIL_W-1:0] fail_next;
    logic              hit_limit;

    // Key decode is only meaningful in ENTRY; every other state ignores the keypad
    // for shift-register purposes, and clr overrides any simultaneous key.
    assign entry_key   = (state == ENTRY) && key_valid && !clr;
    assign full        = (digit_cnt == 3'd4);
    assign digit_ok    = entry_key && (key_code <= 4'd9) && !full;
    assign clear_key   = entry_key && (key_code == KEY_CLEAR);
    assign enter_key   = entry_key && (key_code == KEY_ENTER);
    assign short_enter = enter_key && !full;
    assign fail_next   = fail_cnt + FAIL_W'(1);
    assign hit_limit   = (fail_next == FAIL_LIMIT);

    assign sr_load  = digit_ok;
    assign sr_clr   = clr || (state == CHECK) || clear_key || short_enter;
    assign sr_data  = key_code;
    assign unlocked = (state == OPEN);
    assign alarm    = (state == LOCKOUT);

    always_ff @(posedge clk) begin
        if (clr) begin
            state     <= ENTRY;
            timer     <= '0;
            digit_cnt <= 3'd0;
            fail_cnt  <= '0;
            bad_code  <= 1'b0;
        end else begin
            bad_code <= 1'b0;
            case (state)
                ENTRY: begin
                    if (digit_ok) begin
                        digit_cnt <= digit_cnt + 3'd1;
                    end else if (clear_key) begin
                        digit_cnt <= 3'd0;
                    end else if (enter_key) begin
                        if (full) begin
                            state <= CHECK;
                        end else begin
                            // Short entry fails at once without a compare.
                            digit_cnt <= 3'd0;
                            bad_code  <= 1'b1;
                            fail_cnt  <= fail_next;
                            if (hit_limit) begin
                                state <= LOCKOUT;
                                timer <= LOCK_LOAD;
                            end
                        end
                    end
                end
                CHECK: begin
                    digit_cnt <= 3'd0;
                    if (sr_q == CODE) begin
                        fail_cnt <= '0;
                        state    <= OPEN;
                        timer    <= OPEN_LOAD;
                    end else begin
                        bad_code <= 1'b1;
                        fail_cnt <= fail_next;
                        if (hit_limit) begin
                            state <= LOCKOUT;
                            timer <= LOCK_LOAD;
                        end else begin
                            state <= ENTRY;
                        end
                    end
                end
                OPEN: begin
                    if (key_valid && key_code == KEY_CLEAR) begin
                        state <= ENTRY;
                    end else if (timer == '0) begin
                        state <= ENTRY;
                    end else begin
                        timer <= timer - TMR_W'(1);
                    end
                end
                LOCKOUT: begin
                    if (timer == '0) begin
                        state    <= ENTRY;
                        fail_cnt <= '0;
                    end else begin
                        timer <= timer - TMR_W'(1);
                    end
                end
                default: state <= ENTRY;
            endcase
        end
    end

endmodule
